// File: rtl/xs3_bcd_seq_conv_pkg.sv
// Shared types and constants for the excess-3 / BCD sequential converter.
package xs3_bcd_pkg;

    typedef enum logic {
        MODE_XS3_TO_BCD = 1'b0,
        MODE_BCD_TO_XS3 = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_e;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;

endpackage

// File: rtl/xs3_bcd_seq_conv_if.sv
// Handshake bundle for xs3_bcd_seq_conv; XS3_BCD_ERR_IDX_EN adds the error summary signals.
interface xs3_bcd_seq_conv_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [W-1:0]      in_data;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [DIGITS-1:0] out_err;
`ifdef XS3_BCD_ERR_IDX_EN
    logic              out_err_any;
    logic [IDX_W-1:0]  out_err_idx;
`endif

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
`ifdef XS3_BCD_ERR_IDX_EN
        , input out_err_any, out_err_idx
`endif
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
`ifdef XS3_BCD_ERR_IDX_EN
        , output out_err_any, out_err_idx
`endif
    );

endinterface

// File: rtl/xs3_bcd_seq_conv_digit_conv.sv
// Combinational single-digit converter between excess-3 and BCD with invalid-code flag.
module xs3_digit_conv
    import xs3_bcd_pkg::*;
(
    input  mode_e      mode,
    input  logic [3:0] digit,
    output logic [3:0] result,
    output logic       err
);

    always_comb begin
        result = 4'd0;
        err    = 1'b0;
        if (mode == MODE_XS3_TO_BCD) begin
            if (digit >= XS3_MIN && digit <= XS3_MAX) begin
                result = digit - XS3_OFFSET;
            end else begin
                err = 1'b1;
            end
        end else begin
            if (digit <= BCD_MAX) begin
                result = digit + XS3_OFFSET;
            end else begin
                // Invalid BCD maps to the excess-3 code of zero
                result = XS3_OFFSET;
                err    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xs3_bcd_seq_conv.sv
// Digit-serial excess-3 <-> BCD word converter, one digit per clock.
// Optional macro XS3_BCD_ERR_IDX_EN adds registered out_err_any / out_err_idx.
module xs3_bcd_seq_conv
    import xs3_bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input logic              clk,
    input logic              rst,
    xs3_bcd_seq_conv_if.slave bus
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [W-1:0]      data_q;
    mode_e             mode_q;
    logic [W-1:0]      res_q;
    logic [DIGITS-1:0] err_q;

    logic              accept;
    logic              conv_step;
    logic [3:0]        cur_digit;
    logic [3:0]        dig_res;
    logic              dig_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        conv_step     = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                conv_step = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cur_digit = data_q[{idx_q, 2'b00} +: 4];

    xs3_digit_conv u_digit_conv (
        .mode   (mode_q),
        .digit  (cur_digit),
        .result (dig_res),
        .err    (dig_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            data_q <= '0;
            mode_q <= MODE_XS3_TO_BCD;
            res_q  <= '0;
            err_q  <= '0;
        end else if (accept) begin
            idx_q  <= '0;
            data_q <= bus.in_data;
            mode_q <= mode_e'(bus.in_mode);
            res_q  <= '0;
            err_q  <= '0;
        end else if (conv_step) begin
            res_q[{idx_q, 2'b00} +: 4] <= dig_res;
            err_q[idx_q]               <= dig_err;
            idx_q                      <= idx_q + IDX_W'(1);
        end
    end

    assign bus.out_data = res_q;
    assign bus.out_err  = err_q;

`ifdef XS3_BCD_ERR_IDX_EN
    logic             err_any_q;
    logic [IDX_W-1:0] err_idx_q;

    // Digits arrive in ascending order, so the first error seen is the lowest index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_any_q <= 1'b0;
            err_idx_q <= '0;
        end else if (accept) begin
            err_any_q <= 1'b0;
            err_idx_q <= '0;
        end else if (conv_step && dig_err) begin
            err_any_q <= 1'b1;
            if (!err_any_q) begin
                err_idx_q <= idx_q;
            end
        end
    end

    assign bus.out_err_any = err_any_q;
    assign bus.out_err_idx = err_idx_q;
`endif

endmodule

// File: tb/tb_xs3_bcd_seq_conv.sv
// Self-checking bench for xs3_bcd_seq_conv: vector table, corner sequences, random words vs model.
module tb_xs3_bcd_seq_conv;

    localparam int unsigned DIGITS = 4;

    typedef struct {
        logic        mode;
        logic [15:0] data;
        logic [15:0] exp_data;
        logic [3:0]  exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    xs3_bcd_seq_conv_if #(.DIGITS(DIGITS)) bus ();

    xs3_bcd_seq_conv #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Spec-level model: per-digit +/-3 within the legal window, else error
    function automatic logic [19:0] model(input logic m, input logic [15:0] d);
        int o = 0;
        logic [3:0] e = '0;
        for (int i = 0; i < 4; i++) begin
            int c = (int'(d) >> (4 * i)) & 15;
            if (m == 1'b0) begin
                if (c >= 3 && c <= 12) o = o + ((c - 3) << (4 * i));
                else e[i] = 1'b1;
            end else begin
                if (c <= 9) o = o + ((c + 3) << (4 * i));
                else begin
                    o = o + (3 << (4 * i));
                    e[i] = 1'b1;
                end
            end
        end
        return {e, o[15:0]};
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk({name, "_ready_timeout"}, 0, 1);
    endtask

    task automatic run_word(input string name, input logic m, input logic [15:0] d,
                            input logic [15:0] exp_data, input logic [3:0] exp_err);
        int cnt = 0;
        wait_ready(name);
        bus.in_valid = 1'b1;
        bus.in_mode  = m;
        bus.in_data  = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_mode  = ~m;
        bus.in_data  = 16'($urandom);
        while (bus.out_valid !== 1'b1 && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({name, "_latency"}, cnt, DIGITS);
        chk({name, "_data"}, bus.out_data, exp_data);
        chk({name, "_err"}, bus.out_err, exp_err);
        chk({name, "_in_ready_done"}, bus.in_ready, 1'b0);
`ifdef XS3_BCD_ERR_IDX_EN
        begin
            int li = 0;
            for (int i = DIGITS - 1; i >= 0; i--) if (exp_err[i]) li = i;
            chk({name, "_err_any"}, bus.out_err_any, |exp_err);
            chk({name, "_err_idx"}, bus.out_err_idx, li);
        end
`endif
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({name, "_valid_fall"}, bus.out_valid, 1'b0);
        chk({name, "_ready_back"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        vec_t vecs[6];
        logic [19:0] r;
        logic [15:0] held;
        logic [15:0] exp_q[$];
        int sent, rcvd, changed;

        vecs[0] = '{1'b0, 16'h3456, 16'h0123, 4'b0000};
        vecs[1] = '{1'b1, 16'h9870, 16'hCBA3, 4'b0000};
        vecs[2] = '{1'b0, 16'h3F43, 16'h0010, 4'b0100};
        vecs[3] = '{1'b0, 16'h4444, 16'h1111, 4'b0000};
        vecs[4] = '{1'b1, 16'hABC5, 16'h3338, 4'b1110};
        vecs[5] = '{1'b0, 16'h0D2C, 16'h0009, 4'b1110};

        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("reset_in_ready", bus.in_ready, 1'b1);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_out_data", bus.out_data, 16'h0);
        chk("reset_out_err", bus.out_err, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_word($sformatf("vec%0d", i), vecs[i].mode, vecs[i].data,
                     vecs[i].exp_data, vecs[i].exp_err);
        end

        // Backpressure with in_valid held high: no accept while DONE
        wait_ready("bp");
        bus.in_valid = 1'b1;
        bus.in_mode  = 1'b0;
        bus.in_data  = 16'h3456;
        @(posedge clk); #1;
        bus.in_data  = 16'h5555;
        repeat (DIGITS) @(posedge clk);
        #1;
        chk("bp_valid_up", bus.out_valid, 1'b1);
        held = bus.out_data;
        chk("bp_data", held, 16'h0123);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_valid%0d", i), bus.out_valid, 1'b1);
            chk($sformatf("bp_hold_data%0d", i), bus.out_data, 16'h0123);
            chk($sformatf("bp_hold_ready%0d", i), bus.in_ready, 1'b0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_release_valid", bus.out_valid, 1'b0);
        chk("bp_release_ready", bus.in_ready, 1'b1);

        // Asynchronous reset after the second conversion edge
        bus.in_valid = 1'b1;
        bus.in_mode  = 1'b1;
        bus.in_data  = 16'h1234;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", bus.out_valid, 1'b0);
        chk("rst_mid_data", bus.out_data, 16'h0);
        chk("rst_mid_err", bus.out_err, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ready_back", bus.in_ready, 1'b1);
        run_word("after_rst", 1'b0, 16'h4444, 16'h1111, 4'b0000);

        // Back-to-back with in_valid held high and consumer always ready
        sent = 0; rcvd = 0; changed = 0;
        bus.out_ready = 1'b1;
        bus.in_mode   = 1'b0;
        bus.in_data   = 16'h5678;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 40 && rcvd < 2; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() > 0) begin
                    r = {4'h0, exp_q.pop_front()};
                    chk($sformatf("b2b_data%0d", rcvd), bus.out_data, r[15:0]);
                end else begin
                    chk("b2b_unexpected_word", 1, 0);
                end
                rcvd++;
            end
            if (bus.in_ready === 1'b1 && bus.in_valid === 1'b1) begin
                r = model(bus.in_mode, bus.in_data);
                exp_q.push_back(r[15:0]);
                if (sent == 1) chk("b2b_second_after_first", rcvd, 1);
                sent++;
                changed = 1;
            end
            @(posedge clk); #1;
            if (changed == 1) begin
                changed = 0;
                if (sent == 1) bus.in_data = 16'h9ABC;
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_sent", sent, 2);
        chk("b2b_rcvd", rcvd, 2);
        @(posedge clk); #1;

        for (int i = 0; i < 30; i++) begin
            logic        m;
            logic [15:0] d;
            m = 1'($urandom_range(1, 0));
            d = 16'($urandom);
            r = model(m, d);
            run_word($sformatf("rnd%0d", i), m, d, r[15:0], r[19:16]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xs3_bcd_seq_conv.md
Name: xs3_bcd_seq_conv

Overview:
- Multi-digit, bidirectional code converter between excess-3 and packed BCD.
- Converts one 4-bit digit per clock.
- Accepts a DIGITS-wide word through a valid/ready handshake and returns the converted word with a per-digit invalid-code mask.
- Sits between digit-serial I/O blocks and BCD arithmetic/display logic in the code_converters group.

Parameters:
- DIGITS, 4, number of 4-bit digits per word (legal range 1..16).
- W, 4*DIGITS, derived data width; localparam only, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word
- in_mode  input  1  conversion direction: 0 = excess-3 to BCD, 1 = BCD to excess-3
- in_data  input  W  digits to convert; digit 0 = bits [3:0]
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  W  converted digits
- out_err  output  DIGITS  bit i set = digit i was an invalid code

Behaviour:
- Reset: the clock is single; reset is asynchronous and active-high. On reset:
  - FSM goes to IDLE; in_ready=1; out_valid=0.
  - out_data=0; out_err=0; digit index=0.
- Reset asserted mid-conversion or while in DONE:
  - The word in flight is discarded. No partial output.
  - in_ready returns high in the first cycle after rst deasserts.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, latch in_data, in_mode; clear the result and err registers; idx=0; go to CONV.
- CONV:
  - in_ready=0.
  - Each cycle, convert digit idx and write result[idx] and err[idx]; then idx++.
  - After digit DIGITS-1 is converted, go to DONE.
- DONE:
  - out_valid=1. out_data and out_err are driven from the registers and held stable until the handshake.
  - On out_ready, go to IDLE; out_valid falls on the next cycle.
  - in_ready stays 0 in DONE. No same-cycle accept.
- Latency:
  - Accept edge E0; digits processed on edges E1..E_DIGITS; out_valid is high after edge E_DIGITS.
  - Throughput is one word per DIGITS+2 cycles minimum.
- Digit mapping, excess-3 to BCD:
  - Codes 0x3..0xC map to code-3 (0..9).
  - Codes 0x0-0x2 and 0xD-0xF give digit 0 and set err bit.
- Digit mapping, BCD to excess-3:
  - Codes 0x0..0x9 map to code+3 (0x3..0xC).
  - Codes 0xA-0xF give 0x3 (the excess-3 code of 0) and set err bit.
- Arithmetic is modulo-16 4-bit add/subtract of constant 3 inside the legal range. No carry between digits.
- Changes to in_mode or in_data outside the accept edge have no effect.
- in_valid may be held high across conversions; the next word is accepted only in IDLE.

Optional Feature:
- Macro: XS3_BCD_ERR_IDX_EN.
- Defined: adds two output ports.
  - out_err_any (1): OR of out_err.
  - out_err_idx (width $clog2(DIGITS), minimum 1): index of the lowest set err bit; 0 when none is set.
  - Both are registered, valid with out_valid, and reset to 0.
- Undefined: these ports do not exist; all other behaviour is identical.

Decomposition:
- Package xs3_bcd_pkg holds:
  - mode typedef: MODE_XS3_TO_BCD=0, MODE_BCD_TO_XS3=1.
  - state enum: IDLE, CONV, DONE.
  - constants: XS3_OFFSET=4'd3, BCD_MAX=4'd9, XS3_MIN=4'd3, XS3_MAX=4'd12.
- Sub-module xs3_digit_conv: purely combinational single-digit converter.
  - Inputs: mode, digit.
  - Outputs: result digit, err.
  - Instantiated once and fed by the idx mux.

Test Plan (DIGITS=4):
- Excess-3 to BCD: mode=0, in_data=16'h3456, out_ready=1.
  - out_data=16'h0123, out_err=4'b0000.
  - out_valid high 4 cycles after the accept edge.
- BCD to excess-3: mode=1, in_data=16'h9870.
  - out_data=16'hCBA3, out_err=0.
- Invalid code, mode=0, in_data=16'h3F43:
  - out_data=16'h0010, out_err=4'b0100.
  - With XS3_BCD_ERR_IDX_EN: out_err_any=1, out_err_idx=2.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_valid stays 1, out_data is stable, in_ready=0.
  - out_ready=1 for one cycle, then IDLE with in_ready=1.
- Reset mid-CONV: assert rst asynchronously after E2 of a conversion.
  - out_valid=0, out_data=0, out_err=0 immediately.
  - After release, a new word 16'h4444 with mode=0 gives 16'h1111.
- Back-to-back with in_valid held high:
  - Two words are accepted, the second only after the first DONE handshake.
  - No word is lost or duplicated.
